hms_time_core: RTL and testbench

Single-clock-domain hour:minute:second timekeeping core with a built-in switch front end. It replaces the gated-clock sec/min counter chain with clock-enable counters and adds an hour field, a configurable day wrap and a setup mode with a field-select position. It feeds the BCD split, segment decoders and display scanner, and exposes hour/min/sec, mode, position and a blink strobe for the digits being edited.

---
 rtl/hms_time_core_if.sv | 27 ++
 rtl/hms_time_core.sv | 177 +++++++++++++++++
 tb/tb_hms_time_core.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hms_time_core_if.sv
// Switch inputs and time/status outputs of the hh:mm:ss timekeeping core.
// The core attaches to the slave modport; the environment uses master.
interface hms_time_core_if;
  logic       i_sw_mode;
  logic       i_sw_pos;
  logic       i_sw_inc;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_mode;
  logic [1:0] o_position;
  logic       o_tick;
  logic       o_max_hit_day;
  logic       o_blink;

  modport master (
    output i_sw_mode, i_sw_pos, i_sw_inc,
    input  o_sec, o_min, o_hour, o_mode, o_position,
    input  o_tick, o_max_hit_day, o_blink
  );

  modport slave (
    input  i_sw_mode, i_sw_pos, i_sw_inc,
    output o_sec, o_min, o_hour, o_mode, o_position,
    output o_tick, o_max_hit_day, o_blink
  );
endinterface

// File: rtl/hms_time_core.sv
// Hour:minute:second timekeeping core with debounced switch front end,
// clock-enable counters, configurable day wrap and a field-editing setup mode.
module hms_time_core #(
  parameter int TICK_DIV   = 50000000,
  parameter int HOUR_MAX   = 23,
  parameter int DEB_CYCLES = 500000
) (
  input logic           clk,
  input logic           rst_n,
  hms_time_core_if.slave bus
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(TICK_DIV / 2);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [4:0]    HOUR_LAST = 5'(HOUR_MAX);
  localparam logic [5:0]    MS_LAST   = 6'd59;

  typedef enum logic {CLOCK = 1'b0, SETUP = 1'b1} mode_t;
  typedef enum logic [1:0] {POS_SEC = 2'd0, POS_MIN = 2'd1, POS_HOUR = 2'd2} pos_t;

  logic [2:0]    sw_raw;
  logic [2:0]    sync1, sync2, sample_prev, deb_level, deb_level_d;
  logic [2:0]    press;
  logic [DW-1:0] deb_cnt;
  logic          deb_strobe;
  logic          mode_press, pos_press, inc_press;

  assign sw_raw     = {bus.i_sw_inc, bus.i_sw_pos, bus.i_sw_mode};
  assign deb_strobe = (deb_cnt == DEB_LAST);

  // A level is accepted only when two consecutive strobe samples agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      sample_prev <= '0;
      deb_level   <= '0;
      deb_level_d <= '0;
      deb_cnt     <= '0;
    end else begin
      sync1       <= sw_raw;
      sync2       <= sync1;
      deb_level_d <= deb_level;
      if (deb_strobe) begin
        deb_cnt     <= '0;
        sample_prev <= sync2;
        deb_level   <= (~(sync2 ^ sample_prev) & sync2) |
                       ((sync2 ^ sample_prev) & deb_level);
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  assign press      = deb_level & ~deb_level_d;
  assign mode_press = press[0];
  assign pos_press  = press[1];
  assign inc_press  = press[2];

  mode_t         mode_q, mode_d;
  pos_t          pos_q, pos_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          max_hit_q, max_hit_d;
  logic          leave_setup;
  logic          sec_last, min_last, hour_last;

  assign leave_setup = mode_press && (mode_q == SETUP);
  assign sec_last    = (sec_q == MS_LAST);
  assign min_last    = (min_q == MS_LAST);
  assign hour_last   = (hour_q == HOUR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= CLOCK;
      pos_q     <= POS_SEC;
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      max_hit_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      pos_q     <= pos_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      max_hit_q <= max_hit_d;
    end
  end

  // Leaving setup restarts the second so the first one is full length.
  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    tick_d = (cnt_q == CNT_LAST);
    if (leave_setup) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    pos_d     = pos_q;
    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    max_hit_d = 1'b0;
    case (mode_q)
      CLOCK: begin
        if (tick_q) begin
          if (sec_last) begin
            sec_d = '0;
            if (min_last) begin
              min_d = '0;
              if (hour_last) begin
                hour_d    = '0;
                max_hit_d = 1'b1;
              end else begin
                hour_d = hour_q + 5'd1;
              end
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        if (mode_press) begin
          mode_d = SETUP;
          pos_d  = POS_SEC;
        end
      end
      SETUP: begin
        if (mode_press) begin
          mode_d = CLOCK;
        end else begin
          // Edits wrap within the selected field and never carry.
          if (inc_press) begin
            case (pos_q)
              POS_SEC:  sec_d  = sec_last  ? '0 : sec_q + 6'd1;
              POS_MIN:  min_d  = min_last  ? '0 : min_q + 6'd1;
              POS_HOUR: hour_d = hour_last ? '0 : hour_q + 5'd1;
              default:  ;
            endcase
          end
          if (pos_press) begin
            case (pos_q)
              POS_SEC: pos_d = POS_MIN;
              POS_MIN: pos_d = POS_HOUR;
              default: pos_d = POS_SEC;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.o_sec         = sec_q;
  assign bus.o_min         = min_q;
  assign bus.o_hour        = hour_q;
  assign bus.o_mode        = mode_q;
  assign bus.o_position    = pos_q;
  assign bus.o_tick        = tick_q;
  assign bus.o_max_hit_day = max_hit_q;
  assign bus.o_blink       = (mode_q == CLOCK) || (cnt_q < CNT_HALF);

endmodule

// File: tb/tb_hms_time_core.sv
// Self-checking bench for hms_time_core: two instances (24 h and 12 h wrap)
// share one set of switches; table vectors feed a scoreboard queue.
module tb_hms_time_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw_mode = 1'b0, sw_pos = 1'b0, sw_inc = 1'b0;

  always #5 clk = ~clk;

  hms_time_core_if if_a ();
  hms_time_core_if if_b ();

  assign if_a.i_sw_mode = sw_mode;
  assign if_a.i_sw_pos  = sw_pos;
  assign if_a.i_sw_inc  = sw_inc;
  assign if_b.i_sw_mode = sw_mode;
  assign if_b.i_sw_pos  = sw_pos;
  assign if_b.i_sw_inc  = sw_inc;

  hms_time_core #(.TICK_DIV(10), .HOUR_MAX(23), .DEB_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  hms_time_core #(.TICK_DIV(10), .HOUR_MAX(11), .DEB_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  typedef struct {
    int mode;
    int pos;
    int sec;
    int min;
    int hour_a;
    int hour_b;
    bit chk_time;
  } exp_t;

  typedef struct {
    string     name;
    logic [2:0] sw;
    int        count;
    int        hold;
    exp_t      exp;
  } vec_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  vec_t tbl1[13];
  vec_t tbl2[8];

  function automatic vec_t mkVec(string n, logic [2:0] sw, int cnt, int hold,
                                 int m, int p, int s, int mi, int ha, int hb, bit ct);
    vec_t v;
    v.name = n; v.sw = sw; v.count = cnt; v.hold = hold;
    v.exp.mode = m; v.exp.pos = p; v.exp.sec = s; v.exp.min = mi;
    v.exp.hour_a = ha; v.exp.hour_b = hb; v.exp.chk_time = ct;
    return v;
  endfunction

  task automatic compareValue(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // sw bits are {inc, pos, mode}; driven on the falling edge.
  task automatic pressSwitches(input logic [2:0] sw, input int hold);
    {sw_inc, sw_pos, sw_mode} = sw;
    repeat (hold) @(negedge clk);
    {sw_inc, sw_pos, sw_mode} = 3'b000;
    repeat (20) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < v.count; i++) pressSwitches(v.sw, v.hold);
    exp_q.push_back(v.exp);
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      compareValue({name, " scoreboard empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    compareValue({name, " mode"}, if_a.o_mode, e.mode);
    compareValue({name, " mode b"}, if_b.o_mode, e.mode);
    if (e.pos >= 0) compareValue({name, " position"}, if_a.o_position, e.pos);
    if (e.chk_time) begin
      compareValue({name, " sec"}, if_a.o_sec, e.sec);
      compareValue({name, " min"}, if_a.o_min, e.min);
      compareValue({name, " hour"}, if_a.o_hour, e.hour_a);
      compareValue({name, " hour b"}, if_b.o_hour, e.hour_b);
    end
  endtask

  task automatic checkResetState(input string name);
    compareValue({name, " sec"}, if_a.o_sec, 0);
    compareValue({name, " min"}, if_a.o_min, 0);
    compareValue({name, " hour"}, if_a.o_hour, 0);
    compareValue({name, " mode"}, if_a.o_mode, 0);
    compareValue({name, " position"}, if_a.o_position, 0);
    compareValue({name, " tick"}, if_a.o_tick, 0);
    compareValue({name, " max_hit_day"}, if_a.o_max_hit_day, 0);
    compareValue({name, " blink"}, if_a.o_blink, 1);
    compareValue({name, " hour b"}, if_b.o_hour, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ticks, first_tick, second_tick, s0, win_ticks, guard, cyc;
    int prev_blink, run, transitions;

    tbl1[0]  = mkVec("inc sec x3",       3'b100,  3, 20, 1, 0,  3,  0,  0,  0, 1);
    tbl1[1]  = mkVec("pos to min",       3'b010,  1, 20, 1, 1,  3,  0,  0,  0, 1);
    tbl1[2]  = mkVec("inc min x59",      3'b100, 59, 20, 1, 1,  3, 59,  0,  0, 1);
    tbl1[3]  = mkVec("min wrap no carry",3'b100,  1, 20, 1, 1,  3,  0,  0,  0, 1);
    tbl1[4]  = mkVec("inc min x59 again",3'b100, 59, 20, 1, 1,  3, 59,  0,  0, 1);
    tbl1[5]  = mkVec("pos to hour",      3'b010,  1, 20, 1, 2,  3, 59,  0,  0, 1);
    tbl1[6]  = mkVec("inc hour x23",     3'b100, 23, 20, 1, 2,  3, 59, 23, 11, 1);
    tbl1[7]  = mkVec("pos and inc",      3'b110,  1, 20, 1, 0,  3, 59,  0,  0, 1);
    tbl1[8]  = mkVec("pos x2",           3'b010,  2, 20, 1, 2,  3, 59,  0,  0, 1);
    tbl1[9]  = mkVec("inc hour x23 b",   3'b100, 23, 20, 1, 2,  3, 59, 23, 11, 1);
    tbl1[10] = mkVec("pos wrap to sec",  3'b010,  1, 20, 1, 0,  3, 59, 23, 11, 1);
    tbl1[11] = mkVec("inc sec x56",      3'b100, 56, 20, 1, 0, 59, 59, 23, 11, 1);
    tbl1[12] = mkVec("long hold pos",    3'b010,  1, 60, 1, 1, 59, 59, 23, 11, 1);

    tbl2[0] = mkVec("pos in clock",   3'b010, 1, 20, 0, -1, 0, 0, 0, 0, 0);
    tbl2[1] = mkVec("mode enter",     3'b001, 1, 20, 1,  0, 0, 0, 0, 0, 0);
    tbl2[2] = mkVec("pos step 1",     3'b010, 1, 20, 1,  1, 0, 0, 0, 0, 0);
    tbl2[3] = mkVec("pos step 2",     3'b010, 1, 20, 1,  2, 0, 0, 0, 0, 0);
    tbl2[4] = mkVec("pos step 0",     3'b010, 1, 20, 1,  0, 0, 0, 0, 0, 0);
    tbl2[5] = mkVec("pos step 1 b",   3'b010, 1, 20, 1,  1, 0, 0, 0, 0, 0);
    tbl2[6] = mkVec("mode exit",      3'b001, 1, 20, 0, -1, 0, 0, 0, 0, 0);
    tbl2[7] = mkVec("mode re-enter",  3'b001, 1, 20, 1,  0, 0, 0, 0, 0, 0);

    // Reset is asynchronous: outputs settle before the first clock edge.
    #2;
    checkResetState("initial reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    ticks = 0; first_tick = 0; second_tick = 0;
    for (int c = 1; c <= 700 && ticks < 60; c++) begin
      @(negedge clk);
      if (if_a.o_tick) begin
        ticks++;
        if (ticks == 1) first_tick = c;
        if (ticks == 2) second_tick = c;
      end
    end
    compareValue("ticks within budget", ticks, 60);
    compareValue("first tick cycle", first_tick, 10);
    compareValue("tick period", second_tick - first_tick, 10);
    @(negedge clk);
    compareValue("60 ticks sec", if_a.o_sec, 0);
    compareValue("60 ticks min", if_a.o_min, 1);
    compareValue("60 ticks hour", if_a.o_hour, 0);

    s0 = if_a.o_sec;
    win_ticks = if_a.o_tick ? 1 : 0;
    sw_inc = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 20) sw_inc = 1'b0;
      if (i < 40 && if_a.o_tick) win_ticks++;
    end
    compareValue("inc in clock sec", if_a.o_sec, (s0 + win_ticks) % 60);
    compareValue("inc in clock min", if_a.o_min, 1);
    compareValue("inc in clock mode", if_a.o_mode, 0);

    // Mode press starts together with reset release: setup is entered
    // before the first second elapses, so time is frozen at 00:00:00.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compareValue("mid-run reset min", if_a.o_min, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mkVec("enter setup", 3'b001, 1, 20, 1, 0, 0, 0, 0, 0, 1));
    checkOutput("enter setup");

    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl1[i]);
      checkOutput(tbl1[i].name);
    end

    prev_blink = if_a.o_blink; run = 0; transitions = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_a.o_blink != prev_blink) begin
        if (transitions >= 1) compareValue("blink half period", run, 5);
        transitions++;
        run = 1;
      end else begin
        run++;
      end
      prev_blink = if_a.o_blink;
    end
    compareValue("blink toggles seen", (transitions >= 6) ? 1 : 0, 1);

    // Mode and inc together: only mode applies; then watch the day wrap.
    fork
      begin
        sw_mode = 1'b1; sw_inc = 1'b1;
        repeat (20) @(negedge clk);
        sw_mode = 1'b0; sw_inc = 1'b0;
      end
      begin
        guard = 0;
        do begin
          @(negedge clk);
          guard++;
        end while (if_a.o_mode !== 1'b0 && guard < 40);
        compareValue("exit setup mode", if_a.o_mode, 0);
        compareValue("exit setup mode b", if_b.o_mode, 0);
        cyc = 0;
        do begin
          @(negedge clk);
          cyc++;
        end while (!if_a.o_tick && cyc < 30);
        compareValue("first tick after setup", cyc, 10);
        compareValue("pre-wrap sec", if_a.o_sec, 59);
        compareValue("pre-wrap min", if_a.o_min, 59);
        compareValue("pre-wrap hour", if_a.o_hour, 23);
        compareValue("pre-wrap hour b", if_b.o_hour, 11);
        compareValue("pre-wrap max_hit", if_a.o_max_hit_day, 0);
        @(negedge clk);
        compareValue("day wrap sec", if_a.o_sec, 0);
        compareValue("day wrap min", if_a.o_min, 0);
        compareValue("day wrap hour", if_a.o_hour, 0);
        compareValue("day wrap max_hit", if_a.o_max_hit_day, 1);
        compareValue("day wrap b sec", if_b.o_sec, 0);
        compareValue("day wrap b min", if_b.o_min, 0);
        compareValue("day wrap b hour", if_b.o_hour, 0);
        compareValue("day wrap b max_hit", if_b.o_max_hit_day, 1);
        @(negedge clk);
        compareValue("max_hit one cycle", if_a.o_max_hit_day, 0);
        compareValue("max_hit one cycle b", if_b.o_max_hit_day, 0);
      end
    join
    repeat (20) @(negedge clk);

    sw_mode = 1'b1;
    repeat (3) @(negedge clk);
    sw_mode = 1'b0;
    repeat (20) @(negedge clk);
    compareValue("glitch ignored mode", if_a.o_mode, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl2[i]);
      checkOutput(tbl2[i].name);
    end

    pressSwitches(3'b010, 20);
    compareValue("pre-reset position", if_a.o_position, 1);
    sw_inc = 1'b1;
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("reset during setup");
    @(negedge clk);
    sw_inc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
